ahb_sram_slave: RTL



---
 rtl/ahb_pkg.sv | 46 ++++
 rtl/ahb_sram_array.sv | 34 +++
 rtl/ahb_sram_slave.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and the responder FSM state type.
// Provides HTRANS/HSIZE/HBURST/HRESP constants plus helpers that decode the
// byte-lane mask and the misaligned/oversized transfer error.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_t;

  // Little-endian byte lanes touched by a transfer.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
    case (size)
      HSIZE_BYTE: lane_mask = 4'b0001 << addr;
      HSIZE_HALF: lane_mask = addr[1] ? 4'b1100 : 4'b0011;
      default:    lane_mask = 4'b1111;
    endcase
  endfunction

  // Oversized or misaligned transfers get the two-cycle ERROR response.
  function automatic logic size_error(input logic [2:0] size, input logic [1:0] addr);
    size_error = (size > HSIZE_WORD)
              || ((size == HSIZE_HALF) && addr[0])
              || ((size == HSIZE_WORD) && (addr != 2'b00));
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// ahb_sram_array: 2^DEPTH_LOG2 x 32 synchronous word RAM.
// Ports:
//   i_clk    clock
//   i_we     per-byte write enables (bit n writes bits 8n+7:8n)
//   i_waddr  write word index
//   i_wdata  write data
//   i_raddr  read word index, sampled every edge
//   o_rdata  registered read data (old contents on a same-edge write)
module ahb_sram_array #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  i_clk,
  input  logic [3:0]            i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [31:0]           i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [0:(1 << DEPTH_LOG2)-1];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (i_we[i]) begin
        r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM responder with byte-lane writes, fixed wait
// states, two-cycle ERROR response and write-to-read forwarding.
// Parameters: DEPTH_LOG2 (memory = 2^DEPTH_LOG2 words), WAIT_STATES (0..15).
// Optional build macro AHB_SLV_RAND_WAIT_EN adds 0..3 pseudo-random extra
// stalls per beat from an 8-bit Galois LFSR.
// Ports:
//   I_HCLK, I_HRESET           clock, synchronous active-high reset
//   I_HSEL, I_HADDR, I_HTRANS  address-phase select, address, transfer type
//   I_HWRITE, I_HSIZE, I_HBURST direction, size, burst (burst unused)
//   I_HWDATA                   write data (data phase)
//   I_HREADY                   bus-level ready (previous data phase done)
//   O_HREADY, O_HRESP, O_HRDATA responder ready, response, read data
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        I_HCLK,
  input  logic        I_HRESET,
  input  logic        I_HSEL,
  input  logic [31:0] I_HADDR,
  input  logic [1:0]  I_HTRANS,
  input  logic        I_HWRITE,
  input  logic [2:0]  I_HSIZE,
  input  logic [2:0]  I_HBURST,
  input  logic [31:0] I_HWDATA,
  input  logic        I_HREADY,
  output logic        O_HREADY,
  output logic [1:0]  O_HRESP,
  output logic [31:0] O_HRDATA
);

  state_t                r_state, w_state_nxt;
  logic [4:0]            r_cnt, w_cnt_nxt;
  logic                  r_dp_valid, w_dp_valid_nxt;
  logic                  r_dp_write;
  logic [DEPTH_LOG2-1:0] r_dp_addr;
  logic [3:0]            r_dp_mask;
  logic                  r_fwd;
  logic [31:0]           r_fwd_data;
  logic [3:0]            r_fwd_mask;
  logic [31:0]           r_hrdata;

  logic                  w_accept;
  logic                  w_err;
  logic [3:0]            w_mask;
  logic [4:0]            w_stall;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [DEPTH_LOG2-1:0] w_raddr;
  logic                  w_done;
  logic                  w_rd_show;
  logic [3:0]            w_we;
  logic [31:0]           w_ram_q;
  logic [31:0]           w_rdata;
  logic                  w_unused;

  assign w_unused = ^{I_HBURST, I_HADDR[31:DEPTH_LOG2+2]};

  assign w_idx  = I_HADDR[DEPTH_LOG2+1:2];
  assign w_err  = size_error(I_HSIZE, I_HADDR[1:0]);
  assign w_mask = lane_mask(I_HSIZE, I_HADDR[1:0]);

  // New address phases are only taken while this responder is not stalling.
  assign w_accept = I_HSEL && I_HREADY
                 && ((I_HTRANS == HTRANS_NONSEQ) || (I_HTRANS == HTRANS_SEQ))
                 && ((r_state == S_IDLE) || (r_state == S_ERR2));

`ifdef AHB_SLV_RAND_WAIT_EN
  logic [7:0] r_lfsr;

  always_ff @(posedge I_HCLK) begin
    if (I_HRESET) begin
      r_lfsr <= 8'hA5;
    end else if (w_accept) begin
      r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
    end
  end

  assign w_stall = 5'(WAIT_STATES) + {3'b000, r_lfsr[1:0]};
`else
  assign w_stall = 5'(WAIT_STATES);
`endif

  // A data phase completes in S_IDLE; errored beats never set r_dp_valid.
  assign w_done    = r_dp_valid && (r_state == S_IDLE) && I_HREADY;
  assign w_rd_show = r_dp_valid && !r_dp_write && (r_state == S_IDLE);
  assign w_we      = (w_done && r_dp_write && !I_HRESET) ? r_dp_mask : '0;

  // The read port follows the new address when one is accepted, otherwise it
  // keeps re-reading the pending beat so stalled reads see fresh contents.
  assign w_raddr = w_accept ? w_idx : r_dp_addr;

  ahb_sram_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .i_clk  (I_HCLK),
    .i_we   (w_we),
    .i_waddr(r_dp_addr),
    .i_wdata(I_HWDATA),
    .i_raddr(w_raddr),
    .o_rdata(w_ram_q)
  );

  // The RAM returns pre-write contents when a write lands on the same edge
  // as the read; overlay the bytes that write just stored.
  always_comb begin
    w_rdata = w_ram_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (r_fwd && r_fwd_mask[i]) begin
        w_rdata[8*i +: 8] = r_fwd_data[8*i +: 8];
      end
    end
  end

  assign O_HRDATA = w_rd_show ? w_rdata : r_hrdata;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_dp_valid_nxt = r_dp_valid;
    O_HREADY       = 1'b1;
    O_HRESP        = HRESP_OKAY;
    case (r_state)
      S_IDLE, S_ERR2: begin
        if (r_state == S_ERR2) begin
          O_HRESP = HRESP_ERROR;
        end
        if (I_HREADY) begin
          w_state_nxt    = S_IDLE;
          w_dp_valid_nxt = 1'b0;
          if (w_accept) begin
            if (w_err) begin
              w_state_nxt = S_ERR1;
            end else begin
              w_dp_valid_nxt = 1'b1;
              if (w_stall != 5'd0) begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = w_stall - 5'd1;
              end
            end
          end
        end
      end
      S_WAIT: begin
        O_HREADY = 1'b0;
        if (r_cnt == 5'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 5'd1;
        end
      end
      S_ERR1: begin
        O_HREADY    = 1'b0;
        O_HRESP     = HRESP_ERROR;
        w_state_nxt = S_ERR2;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge I_HCLK) begin
    if (I_HRESET) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_addr  <= '0;
      r_dp_mask  <= '0;
      r_fwd      <= 1'b0;
      r_fwd_data <= '0;
      r_fwd_mask <= '0;
      r_hrdata   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_dp_valid <= w_dp_valid_nxt;
      if (w_accept) begin
        r_dp_write <= I_HWRITE;
        r_dp_addr  <= w_idx;
        r_dp_mask  <= w_mask;
      end
      r_fwd      <= w_done && r_dp_write && (w_raddr == r_dp_addr);
      r_fwd_data <= I_HWDATA;
      r_fwd_mask <= r_dp_mask;
      if (w_rd_show) begin
        r_hrdata <= w_rdata;
      end
    end
  end

endmodule
